// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared widths and FSM state encoding for the obstacle line fetcher.
package obstacle_pkg;
    localparam int OBST_ADDR_W = 11;
    localparam int OBST_DATA_W = 32;
    localparam int PX_PER_WORD = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_e;
endpackage

// File: rtl/obstacle_word_fifo.sv
// obstacle_word_fifo: 2-entry word FIFO with occupancy output; the caller never pushes when full.
module obstacle_word_fifo
    import obstacle_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [OBST_DATA_W-1:0] data_i,
    output logic [OBST_DATA_W-1:0] head_o,
    output logic [1:0]             count_o
);
    logic [OBST_DATA_W-1:0] mem_q [2];
    logic                   wr_q, rd_q;
    logic [1:0]             count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop_i) rd_q <= ~rd_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/obstacle_line_fetch.sv
// obstacle_line_fetch: Avalon-MM read master streaming one scrolled bitmap row as 1-bit pixels.
// Optional statistics counters are built when OBSTACLE_LINE_FETCH_STATS_EN is defined.
module obstacle_line_fetch
    import obstacle_pkg::*;
#(
    parameter int WORDS_PER_LINE = 20,
    parameter int ROW_BITS       = 7,
    parameter int BASE_ADDR      = 0
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   line_req,
    input  logic [ROW_BITS-1:0]    line_row,
    input  logic [4:0]             scroll_word,
    output logic                   busy,
    output logic                   line_done,
    output logic                   overrun,
    output logic [OBST_ADDR_W-1:0] m_address,
    output logic                   m_chipselect,
    output logic                   m_clken,
    output logic                   m_write,
    output logic [3:0]             m_byteenable,
    output logic [OBST_DATA_W-1:0] m_writedata,
    input  logic [OBST_DATA_W-1:0] m_readdata,
    output logic                   px_valid,
    input  logic                   px_ready,
    output logic                   px_data,
    output logic                   px_last,
    output logic [15:0]            line_count,
    output logic [15:0]            overrun_count
);
    localparam logic [4:0] W_LAST  = 5'(WORDS_PER_LINE - 1);
    localparam logic [4:0] W_NUM   = 5'(WORDS_PER_LINE);
    localparam logic [4:0] BIT_END = 5'(PX_PER_WORD - 1);

    state_e                 state_q, state_d;
    logic [OBST_ADDR_W-1:0] base_q, base_d, addr_q, addr_d, req_base;
    logic [4:0]             widx_q, widx_d, cnt_q, cnt_d, bit_q, bit_d, pops_q, pops_d, scroll_c;
    logic                   cs_q, cs_d, rv_q, done_q, done_d, overrun_q;
    logic                   accept, hs, pop;
    logic [1:0]             occ;
    logic [OBST_DATA_W-1:0] head;

    function automatic logic [4:0] next_idx(input logic [4:0] w);
        return (w == W_LAST) ? 5'd0 : w + 5'd1;
    endfunction

    assign scroll_c = (scroll_word >= W_NUM) ? 5'd0 : scroll_word;
    assign req_base = OBST_ADDR_W'(BASE_ADDR + int'(line_row) * WORDS_PER_LINE);
    // A request coinciding with the done pulse is dropped so lines never overlap.
    assign accept   = (state_q == ST_IDLE) && line_req && !done_q;
    assign px_valid = occ != 2'd0;
    assign px_data  = head[~bit_q];
    assign px_last  = px_valid && (bit_q == BIT_END) && (pops_q == W_LAST);
    assign hs       = px_valid && px_ready;
    assign pop      = hs && (bit_q == BIT_END);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        widx_d  = widx_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        done_d  = 1'b0;
        bit_d   = hs ? bit_q + 5'd1 : bit_q;
        pops_d  = pop ? pops_q + 5'd1 : pops_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = (W_LAST == 5'd0) ? ST_DRAIN : ST_FETCH;
                base_d  = req_base;
                addr_d  = req_base + OBST_ADDR_W'(scroll_c);
                widx_d  = next_idx(scroll_c);
                cnt_d   = 5'd1;
                cs_d    = 1'b1;
                bit_d   = 5'd0;
                pops_d  = 5'd0;
            end
            // Buffered plus in-flight words never exceed the two FIFO slots.
            ST_FETCH: if (({1'b0, occ} + {2'b0, cs_q} + {2'b0, rv_q}) < 3'd2) begin
                cs_d   = 1'b1;
                addr_d = base_q + OBST_ADDR_W'(widx_q);
                widx_d = next_idx(widx_q);
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == W_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (px_last && px_ready) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            widx_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            pops_q    <= '0;
            cs_q      <= 1'b0;
            rv_q      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            widx_q    <= widx_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pops_q    <= pops_d;
            cs_q      <= cs_d;
            rv_q      <= cs_q;
            done_q    <= done_d;
            overrun_q <= overrun_q | (line_req && state_q != ST_IDLE);
        end
    end

    obstacle_word_fifo u_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .push_i  (rv_q),
        .pop_i   (pop),
        .data_i  (m_readdata),
        .head_o  (head),
        .count_o (occ)
    );

`ifdef OBSTACLE_LINE_FETCH_STATS_EN
    logic [15:0] lines_q, ovr_cnt_q;
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lines_q   <= '0;
            ovr_cnt_q <= '0;
        end else begin
            if (done_d && lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
            if (line_req && !accept && ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end
    assign line_count    = lines_q;
    assign overrun_count = ovr_cnt_q;
`else
    assign line_count    = 16'd0;
    assign overrun_count = 16'd0;
`endif

    assign busy         = state_q != ST_IDLE;
    assign line_done    = done_q;
    assign overrun      = overrun_q;
    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_clken      = 1'b1;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_writedata  = '0;
endmodule

// File: tb/tb_obstacle_line_fetch.sv
// tb_obstacle_line_fetch: directed and randomized line fetches checked against a row/scroll pixel model.
module tb_obstacle_line_fetch;
    localparam int W = 20;
`ifdef OBSTACLE_LINE_FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, line_req = 1'b0, px_ready = 1'b0;
    logic [6:0]  line_row = '0;
    logic [4:0]  scroll_word = '0;
    logic [31:0] m_readdata = '0;
    logic        busy, line_done, overrun, m_chipselect, m_clken, m_write, px_valid, px_data, px_last;
    logic [10:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic [15:0] line_count, overrun_count;

    logic [31:0] mem [2048];
    logic [31:0] first_word;
    int checks = 0, errors = 0, lines = 0, ovrs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (m_chipselect) m_readdata <= mem[m_address];

    obstacle_line_fetch dut (
        .clk_clk(clk), .reset_reset(rst), .line_req(line_req), .line_row(line_row),
        .scroll_word(scroll_word), .busy(busy), .line_done(line_done), .overrun(overrun),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_clken(m_clken), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_last(px_last),
        .line_count(line_count), .overrun_count(overrun_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", line_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_cs", m_chipselect, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_valid", px_valid, 0);
        chk("rst_line_count", line_count, 0);
        chk("rst_overrun_count", overrun_count, 0);
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: random ready
    task automatic run_line(input int row, input int scroll, input int mode, input int ovr_at, input int abort_at);
        int exp_addr[$];
        bit exp_px[$];
        int s, issued, hsn, done_k, first_v;
        s = (scroll >= W) ? 0 : scroll;
        for (int j = 0; j < W; j++) begin
            int a;
            a = (row * W + (s + j) % W) % 2048;
            exp_addr.push_back(a);
            for (int b = 31; b >= 0; b--) exp_px.push_back(mem[a][b]);
        end
        @(negedge clk);
        line_row = 7'(row);
        scroll_word = 5'(scroll);
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
        issued = 0; hsn = 0; done_k = -1; first_v = -1; first_word = '0;
        for (int k = 0; k < 8000 && done_k < 0; k++) begin
            px_ready = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : ($urandom_range(3) != 0);
            line_req = (k == ovr_at);
            if (k == 0) chk("busy_start", busy, 1);
            if (m_chipselect) begin
                chk("read_in_range", issued < W, 1);
                if (issued < W) chk("addr", m_address, exp_addr[issued]);
                issued++;
                chk("inflight_le2", (issued - hsn / 32) <= 2, 1);
            end
            if (px_valid && first_v < 0) first_v = k;
            if (px_valid && px_ready) begin
                chk("px_in_range", hsn < 32 * W, 1);
                if (hsn < 32 * W) begin
                    chk("px_data", px_data, exp_px[hsn]);
                    chk("px_last", px_last, hsn == 32 * W - 1);
                end
                if (hsn < 32) first_word = {first_word[30:0], px_data};
                hsn++;
            end
            if (line_done) begin
                done_k = k;
                chk("busy_end", busy, 0);
            end
            if (abort_at >= 0 && hsn == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_vals();
                lines = 0;
                ovrs = 0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done_k < 0) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        line_req = 1'b0;
        chk("done_seen", done_k >= 0, 1);
        chk("pixel_total", hsn, 32 * W);
        chk("read_total", issued, W);
        if (mode == 0) chk("first_valid_cycle", first_v, 2);
        if (mode == 0) chk("done_cycle", done_k, 2 + 32 * W);
        if (mode == 1) chk("done_cycle_toggle", done_k, 2 + 64 * W);
        if (ovr_at >= 0) begin
            ovrs++;
            chk("overrun_set", overrun, 1);
        end
        lines++;
        chk("line_count", line_count, STATS ? lines : 0);
        chk("overrun_count", overrun_count, STATS ? ovrs : 0);
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = $urandom;
        mem[0] = 32'h80000001;
        #1;
        check_reset_vals();
        chk("tie_clken", m_clken, 1);
        chk("tie_write", m_write, 0);
        chk("tie_be", m_byteenable, 4'hF);
        chk("tie_wdata", m_writedata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_line(0, 0, 0, -1, -1);
        chk("first_word_pixels", first_word, 32'h80000001);
        run_line(3, 18, 0, -1, -1);
        run_line(5, 7, 1, -1, -1);
        run_line(2, 4, 0, 300, -1);
        run_line(6, 25, 0, -1, -1);
        chk("overrun_sticky", overrun, 1);
        for (int n = 0; n < 4; n++) run_line($urandom_range(127), $urandom_range(31), 2, -1, -1);
        run_line(9, 3, 0, -1, 100);
        run_line(1, 0, 0, -1, -1);
        chk("overrun_cleared", overrun, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obstacle_line_fetch.md
# obstacle_line_fetch

Avalon-MM read master that streams one scan line of the obstacle bitmap out of the obstacle on-chip memory (11-bit word address, 32-bit data, fixed read latency 1) and serialises it into a 1-bit-per-pixel stream for the renderer. It sits between the obstacle memory's s1 slave port and the pixel compositor. It applies a word-granular horizontal scroll with wrap-around inside the row, so the game scrolls obstacles by changing one register rather than rewriting memory.

## Interface
- WORDS_PER_LINE, 20, 32-pixel words per bitmap row (640 px); range 1..31
- ROW_BITS, 7, width of row index
- BASE_ADDR, 0, word address of row 0
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- line_req  in  1  single-cycle request to fetch one line
- line_row  in  ROW_BITS  bitmap row, sampled with line_req
- scroll_word  in  5  first word index, sampled with line_req
- busy  out  1  line in progress
- line_done  out  1  one-cycle pulse after last pixel accepted
- overrun  out  1  sticky: line_req seen while busy; cleared by reset only
- m_address  out  11  memory word address
- m_chipselect  out  1  read strobe
- m_clken  out  1  tied 1
- m_write  out  1  tied 0
- m_byteenable  out  4  tied 4'hF
- m_writedata  out  32  tied 0
- m_readdata  in  32  read data, valid one cycle after the strobe
- px_valid  out  1  pixel available
- px_ready  in  1  consumer accepts pixel
- px_data  out  1  1 = obstacle pixel
- px_last  out  1  last pixel of the line
- line_count, overrun_count  out  16 each  statistics (see Configuration)

## Operation
- FSM: IDLE, FETCH, DRAIN. Reset -> IDLE.
- IDLE: line_req=1 latches row, scroll (scroll_word >= WORDS_PER_LINE treated as 0), clears word index i and pixel bit counter -> FETCH.
- FETCH: issue one read per cycle while (FIFO occupancy + reads in flight) < 2; address = BASE_ADDR + row*WORDS_PER_LINE + ((scroll + i) mod WORDS_PER_LINE), truncated to 11 bits. After read WORDS_PER_LINE-1 is issued -> DRAIN.
- DRAIN: no reads; wait for last pixel handshake -> IDLE, pulse line_done.
- Returned words go into a 2-entry word FIFO. px_valid = FIFO non-empty; px_data = head[31-bit], MSB first. Handshake px_valid & px_ready advances bit; on bit 31 the head word pops.
- px_last = px_valid on bit 0 of word WORDS_PER_LINE-1 (bit 31 of head, counting MSB first, on final word).
- line_req while busy: ignored, overrun set. line_req on the same cycle as line_done: ignored (accepted only in IDLE).
- px_ready low stalls the stream indefinitely; no data lost, reads throttle via the occupancy rule.
- busy = state != IDLE.

## Timing
- All outputs registered except px_valid/px_data/px_last (combinational from FIFO head and bit counter).
- Reset values: busy 0, line_done 0, overrun 0, m_chipselect 0, m_address 0, FIFO empty (px_valid 0), counters 0.
- line_req sampled at edge E0 -> m_chipselect/m_address valid after E0 -> memory samples at E1 -> word written to FIFO at E2 -> px_valid high after E2 (2-cycle latency).
- Sustained rate with px_ready=1: 1 pixel/cycle, no bubbles after first pixel.
- Line of WORDS_PER_LINE words with px_ready=1: line_done asserted 2 + 32*WORDS_PER_LINE cycles after E0.
- Reset mid-line: asynchronous clear of FSM, FIFO, in-flight tracking; strobe drops immediately; late readdata ignored.

## Configuration
- OBSTACLE_LINE_FETCH_STATS_EN defined: line_count increments on each line_done, overrun_count on each ignored line_req; both saturate at 16'hFFFF.
- Not defined: counters not built, line_count and overrun_count tied to 0; ports remain.

## Structure
- Package obstacle_pkg: FSM state enum, OBST_ADDR_W=11, OBST_DATA_W=32, PX_PER_WORD=32.
- One sub-module: obstacle_word_fifo (2-entry, synchronous push/pop, occupancy output). Address arithmetic and serialiser stay in the top.

## Test plan
- Reset, line_req with row=0, scroll=0, px_ready=1 -> addresses 0..19 in order, px_valid 2 cycles after request, 640 pixels, px_last on 640th, line_done at cycle 642.
- Row=3, scroll=18 -> addresses 78,79,60,61,...,77; pixel order matches memory words in that sequence, MSB first.
- Word 0x80000001 at first address -> pixels 1,0,...,0,1 for first 32 handshakes.
- px_ready toggling 1/0 every cycle -> no pixel lost or duplicated, never more than 2 words buffered plus in flight, line_done at cycle 1282.
- line_req during busy -> ignored, overrun=1 until reset; with STATS_EN overrun_count=1.
- reset_reset asserted at pixel 100 -> all outputs to reset values that cycle; next line_req row=1 produces addresses 20..39 cleanly.
